multirate_interp_polyphase: RTL and testbench

Polyphase interpolating FIR, upsample factor L. It is the synthesis-side counterpart to the decimating analysis filterbank. Each accepted input sample produces L output samples, one per polyphase branch. Computation is sequential MAC on one 16s×15ns→31 multiplier (same arithmetic as the filterbank's multiply primitive); coefficients are runtime-loadable.

---
 rtl/multirate_interp_polyphase_if.sv | 28 ++
 rtl/multirate_interp_polyphase.sv | 125 ++++++++++++
 tb/tb_multirate_interp_polyphase.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/multirate_interp_polyphase_if.sv
// Stream-in / stream-out / coefficient-write bundle for the polyphase interpolator.
// slave is the filter side, master is the side that feeds samples and coefficients.
interface multirate_interp_polyphase_if #(
  parameter int DIN_W  = 16,
  parameter int COEF_W = 15,
  parameter int ADDR_W = 3
);
  logic signed [DIN_W-1:0]  s_data;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DIN_W-1:0]  m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     coef_we;
  logic        [ADDR_W-1:0] coef_addr;
  logic        [COEF_W-1:0] coef_data;
  logic                     coef_ready;

  modport master (
    output s_data, s_valid, m_ready, coef_we, coef_addr, coef_data,
    input  s_ready, m_data, m_valid, coef_ready
  );

  modport slave (
    input  s_data, s_valid, m_ready, coef_we, coef_addr, coef_data,
    output s_ready, m_data, m_valid, coef_ready
  );
endinterface

// File: rtl/multirate_interp_polyphase.sv
// Polyphase interpolating FIR: each accepted sample yields L outputs, one per phase,
// computed by a sequential multiply-accumulate over TAPS runtime-loadable coefficients.
module multirate_interp_polyphase #(
  parameter int L      = 2,
  parameter int TAPS   = 4,
  parameter int DIN_W  = 16,
  parameter int COEF_W = 15,
  parameter int ACC_W  = 34,
  parameter int SHIFT  = 14
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  multirate_interp_polyphase_if.slave  bus
);
  localparam int NCOEF  = L * TAPS;
  localparam int AW     = (NCOEF > 1) ? $clog2(NCOEF) : 1;
  localparam int PW     = $clog2(L);
  localparam int KW     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int PROD_W = DIN_W + COEF_W;

  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((longint'(1) <<< (DIN_W-1)) - longint'(1));
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-(longint'(1) <<< (DIN_W-1)));

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state;
  logic signed [DIN_W-1:0]   x [TAPS];
  logic        [COEF_W-1:0]  coef [NCOEF];
  logic signed [ACC_W-1:0]   acc;
  logic        [PW-1:0]      p;
  logic        [KW-1:0]      k;
  logic signed [DIN_W-1:0]   m_data_r;
  logic                      m_valid_r;
  logic                      s_ready_r;
  logic                      coef_ready_r;

  logic        [AW-1:0]      cidx;
  logic signed [ACC_W-1:0]   acc_sum;

  // Signed sample times unsigned coefficient; the coefficient gets a zero sign bit.
  function automatic logic signed [PROD_W-1:0] mul(input logic signed [DIN_W-1:0] xv,
                                                   input logic        [COEF_W-1:0] cv);
    logic signed [PROD_W-1:0] xe;
    logic signed [PROD_W-1:0] ce;
    xe = PROD_W'(xv);
    ce = $signed(PROD_W'(cv));
    return xe * ce;
  endfunction

  function automatic logic signed [DIN_W-1:0] sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> SHIFT;
    if (s > MAXV)      return DIN_W'(MAXV);
    else if (s < MINV) return DIN_W'(MINV);
    else               return DIN_W'(s);
  endfunction

  always_comb begin
    cidx    = AW'(int'(p) * TAPS + int'(k));
    acc_sum = acc + ACC_W'(mul(x[k], coef[cidx]));
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      p            <= '0;
      k            <= '0;
      m_data_r     <= '0;
      m_valid_r    <= 1'b0;
      s_ready_r    <= 1'b1;
      coef_ready_r <= 1'b1;
      for (int i = 0; i < TAPS; i++)  x[i]    <= '0;
      for (int i = 0; i < NCOEF; i++) coef[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A write landing with a sample accept is visible to that sample's first MAC.
          if (bus.coef_we && coef_ready_r && (32'(bus.coef_addr) < NCOEF))
            coef[bus.coef_addr] <= bus.coef_data;
          if (bus.s_valid && s_ready_r) begin
            for (int i = TAPS-1; i > 0; i--) x[i] <= x[i-1];
            x[0]         <= bus.s_data;
            p            <= '0;
            k            <= '0;
            acc          <= '0;
            s_ready_r    <= 1'b0;
            coef_ready_r <= 1'b0;
            state        <= MAC;
          end
        end
        MAC: begin
          acc <= acc_sum;
          k   <= k + KW'(1);
          if (k == KW'(TAPS-1)) begin
            m_data_r  <= sat(acc_sum);
            m_valid_r <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_r <= 1'b0;
            if (p != PW'(L-1)) begin
              p     <= p + PW'(1);
              k     <= '0;
              acc   <= '0;
              state <= MAC;
            end else begin
              s_ready_r    <= 1'b1;
              coef_ready_r <= 1'b1;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_ready    = s_ready_r;
  assign bus.coef_ready = coef_ready_r;
  assign bus.m_data     = m_data_r;
  assign bus.m_valid    = m_valid_r;
endmodule

// File: tb/tb_multirate_interp_polyphase.sv
// Bench for multirate_interp_polyphase: two instances (SHIFT=0 and SHIFT=14) share one
// stimulus stream; a reference model queues expected outputs for each at sample accept.
module tb_multirate_interp_polyphase;
  localparam int L = 2, TAPS = 4, DIN_W = 16, COEF_W = 15, ACC_W = 34, AW = 3;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic signed [DIN_W-1:0] s_data = '0;
  logic                    s_valid = 1'b0;
  logic                    m_ready = 1'b1;
  logic                    coef_we = 1'b0;
  logic [AW-1:0]           coef_addr = '0;
  logic [COEF_W-1:0]       coef_data = '0;

  multirate_interp_polyphase_if #(.DIN_W(DIN_W), .COEF_W(COEF_W), .ADDR_W(AW)) b0 ();
  multirate_interp_polyphase_if #(.DIN_W(DIN_W), .COEF_W(COEF_W), .ADDR_W(AW)) b14 ();

  assign b0.s_data = s_data;     assign b14.s_data = s_data;
  assign b0.s_valid = s_valid;   assign b14.s_valid = s_valid;
  assign b0.m_ready = m_ready;   assign b14.m_ready = m_ready;
  assign b0.coef_we = coef_we;   assign b14.coef_we = coef_we;
  assign b0.coef_addr = coef_addr; assign b14.coef_addr = coef_addr;
  assign b0.coef_data = coef_data; assign b14.coef_data = coef_data;

  multirate_interp_polyphase #(.L(L), .TAPS(TAPS), .DIN_W(DIN_W), .COEF_W(COEF_W),
                               .ACC_W(ACC_W), .SHIFT(0))
    dut0 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(b0));
  multirate_interp_polyphase #(.L(L), .TAPS(TAPS), .DIN_W(DIN_W), .COEF_W(COEF_W),
                               .ACC_W(ACC_W), .SHIFT(14))
    dut14 (.ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(b14));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  longint q0[$];
  longint q14[$];
  longint mcoef[L*TAPS];
  longint mx[TAPS];

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint msat(input longint a);
    if (a > 32767)  return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  // Outputs are compared the half cycle before the handshake edge.
  always @(negedge ap_clk) begin
    if (ap_rst_n && b0.m_valid && m_ready) begin
      chk("q0_nonempty", (q0.size() > 0), 1);
      if (q0.size() > 0) chk("out_shift0", b0.m_data, q0.pop_front());
    end
    if (ap_rst_n && b14.m_valid && m_ready) begin
      chk("q14_nonempty", (q14.size() > 0), 1);
      if (q14.size() > 0) chk("out_shift14", b14.m_data, q14.pop_front());
    end
  end

  task automatic wcoef(input int a, input int d);
    int n;
    n = 0;
    coef_we = 1'b1; coef_addr = AW'(a); coef_data = COEF_W'(d);
    while (!b0.coef_ready && n < 200) begin @(posedge ap_clk); #1; n++; end
    chk("coef_ready_for_write", b0.coef_ready, 1);
    mcoef[a] = d;
    @(posedge ap_clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic send(input int d, input bit we = 1'b0, input int a = 0, input int cd = 0);
    int n;
    n = 0;
    s_data = DIN_W'(d); s_valid = 1'b1;
    coef_we = we; coef_addr = AW'(a); coef_data = COEF_W'(cd);
    while (!b0.s_ready && n < 200) begin @(posedge ap_clk); #1; n++; end
    chk("s_ready_for_accept", b0.s_ready, 1);
    if (we) mcoef[a] = cd;
    for (int i = TAPS-1; i > 0; i--) mx[i] = mx[i-1];
    mx[0] = d;
    for (int ph = 0; ph < L; ph++) begin
      longint acc;
      acc = 0;
      for (int t = 0; t < TAPS; t++) acc += mx[t] * mcoef[ph*TAPS + t];
      q0.push_back(msat(acc));
      q14.push_back(msat(acc >>> 14));
    end
    @(posedge ap_clk); #1;
    acc_cyc = cyc;
    s_valid = 1'b0; coef_we = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!b0.m_valid && n < 100) begin @(posedge ap_clk); #1; n++; end
    chk("m_valid_arrives", b0.m_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q14.size() != 0 || !b0.s_ready) && n < 500) begin
      @(posedge ap_clk); #1; n++;
    end
    chk("drain_q0_empty", q0.size(), 0);
    chk("drain_q14_empty", q14.size(), 0);
    chk("drain_idle", b0.s_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a1;
    logic signed [DIN_W-1:0] held;
    for (int i = 0; i < L*TAPS; i++) mcoef[i] = 0;
    for (int i = 0; i < TAPS; i++) mx[i] = 0;

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_m_valid", b0.m_valid, 0);
    chk("rst_m_data", b0.m_data, 0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("rel_s_ready", b0.s_ready, 1);
    chk("rel_coef_ready", b0.coef_ready, 1);
    chk("rel_m_valid", b0.m_valid, 0);
    chk("rel_m_data14", b14.m_data, 0);

    // Impulse with ramp coefficients, latency and input spacing.
    m_ready = 1'b1;
    for (int i = 0; i < L*TAPS; i++) wcoef(i, i + 1);
    send(1);
    a1 = acc_cyc;
    wait_valid();
    chk("first_handshake_latency", (cyc + 1) - a1, TAPS + 1);
    send(0);
    chk("input_spacing", acc_cyc - a1, L*(TAPS+1) + 1);
    send(0);
    send(0);
    drain();

    // Saturation at both rails.
    for (int i = 0; i < L*TAPS; i++) wcoef(i, 32767);
    for (int i = 0; i < 4; i++) send(32767);
    for (int i = 0; i < 4; i++) send(-32768);
    drain();

    // Scaling and sign.
    wcoef(0, 16384);
    for (int i = 1; i < L*TAPS; i++) wcoef(i, 0);
    send(-1000);
    drain();

    // Backpressure holds the output.
    m_ready = 1'b0;
    send(-1000);
    wait_valid();
    held = b0.m_data;
    chk("bp_first_value14", b14.m_data, -1000);
    for (int i = 0; i < 6; i++) begin
      @(posedge ap_clk); #1;
      chk("bp_m_valid", b0.m_valid, 1);
      chk("bp_m_data", b0.m_data, held);
      chk("bp_s_ready", b0.s_ready, 0);
      chk("bp_coef_ready", b0.coef_ready, 0);
    end
    m_ready = 1'b1;
    drain();

    // Coefficient writes outside IDLE are dropped; a write alongside an accept is used.
    for (int i = 0; i < L*TAPS; i++) wcoef(i, i + 1);
    for (int i = 0; i < 4; i++) send(0);
    send(1);
    coef_we = 1'b1; coef_addr = '0; coef_data = COEF_W'(999);
    @(posedge ap_clk); #1;
    chk("mac_coef_ready", b0.coef_ready, 0);
    coef_we = 1'b0;
    drain();
    send(1, 1'b1, 0, 100);
    drain();

    // Reset during phase-1 MAC.
    send(1);
    begin
      int n;
      n = 0;
      while (q0.size() > 1 && n < 100) begin @(posedge ap_clk); #1; n++; end
      chk("phase0_out_seen", q0.size(), 1);
    end
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    q0.delete(); q14.delete();
    for (int i = 0; i < L*TAPS; i++) mcoef[i] = 0;
    for (int i = 0; i < TAPS; i++) mx[i] = 0;
    #1;
    chk("midrst_m_valid", b0.m_valid, 0);
    chk("midrst_m_data", b0.m_data, 0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    @(posedge ap_clk); #1;
    chk("midrst_s_ready", b0.s_ready, 1);
    chk("midrst_coef_ready", b0.coef_ready, 1);
    send(1);
    send(0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
